// File: rtl/wave_frame_prep_pkg.sv
// wave_frame_prep_pkg: shared types and constants for the waveform frame feeder and matcher
package wave_frame_prep_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        NORM,
        STREAM,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        N_RD,
        N_SUB,
        N_DIV
    } norm_ph_t;

    typedef enum logic [1:0] {
        TRI = 2'd0,
        SQR = 2'd1,
        SIN = 2'd2
    } wave_type_t;

    localparam logic [7:0] DERIV_ZERO = 8'd128;
    localparam logic [7:0] FLAT_LEVEL = 8'd128;
    localparam logic [7:0] FULL_SCALE = 8'd255;

    function automatic logic [7:0] clamp_u8(input logic signed [9:0] v);
        return v < 10'sd0 ? 8'd0 : v > 10'sd255 ? 8'd255 : v[7:0];
    endfunction

endpackage

// File: rtl/wave_frame_prep_if.sv
// wave_frame_prep_if: control, ADC capture and normalised stream bundle
interface wave_frame_prep_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic [7:0]        adc_data;
    logic              adc_valid;
    logic              busy;
    logic [ADDR_W-1:0] tmpl_addr;
    logic              wave_valid;
    logic [7:0]        wave_out;
    logic [7:0]        dwave_out;
    logic              frame_done;

    modport master (
        output start, adc_data, adc_valid,
        input  busy, tmpl_addr, wave_valid, wave_out, dwave_out, frame_done
    );

    modport slave (
        input  start, adc_data, adc_valid,
        output busy, tmpl_addr, wave_valid, wave_out, dwave_out, frame_done
    );
endinterface

// File: rtl/wave_frame_prep_seq_div_u16_u8.sv
// seq_div_u16_u8: restoring divider, one quotient bit per cycle, done 16 cycles after start
module seq_div_u16_u8 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        done,
    output logic [7:0]  quotient
);
    logic [15:0] q;
    logic [7:0]  rem;
    logic [7:0]  dv;
    logic [4:0]  cnt;
    logic [8:0]  trial;
    logic [8:0]  diff;
    logic        ge;

    // remainder never reaches the divisor, so 8 bits plus the shifted-in bit suffice
    always_comb begin
        trial = {rem, q[15]};
        diff  = trial - {1'b0, dv};
        ge    = trial >= {1'b0, dv};
    end

    // load on start, then shift one dividend bit into the remainder per cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q    <= '0;
            rem  <= '0;
            dv   <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                q   <= dividend;
                rem <= '0;
                dv  <= divisor;
                cnt <= 5'd16;
            end else if (cnt != 5'd0) begin
                q    <= {q[14:0], ge};
                rem  <= ge ? diff[7:0] : trial[7:0];
                cnt  <= cnt - 5'd1;
                done <= cnt == 5'd1;
            end
        end
    end

    assign quotient = q[7:0];
endmodule

// File: rtl/wave_frame_prep.sv
// wave_frame_prep: capture an ADC frame, normalise it in place, stream it with its first difference
module wave_frame_prep
    import wave_frame_prep_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int TMPL_LAT = 1
) (
    input logic              clk,
    input logic              rst_n,
    wave_frame_prep_if.slave bus
);
    localparam int FRAME_LEN = 1 << ADDR_W;
    localparam logic [ADDR_W+1:0] PIPE = (ADDR_W+2)'(2);
    localparam logic [ADDR_W+1:0] LEAD = (ADDR_W+2)'(2 - TMPL_LAT);

    state_t            state;
    norm_ph_t          ph;
    logic [ADDR_W-1:0] idx;
    logic [7:0]        mn;
    logic [7:0]        mx;
    logic [7:0]        rng;
    logic [7:0]        diff;
    logic [ADDR_W+1:0] scnt;
    logic [ADDR_W+1:0] nxt;
    logic [ADDR_W+1:0] ta;
    logic [ADDR_W+1:0] vi;
    logic signed [9:0] slope;
    logic [7:0]        ram [FRAME_LEN];
    logic [7:0]        rd_q;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wd;
    logic              div_start;
    logic              div_done;
    logic [15:0]       div_num;
    logic [7:0]        div_q;

    seq_div_u16_u8 u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (div_num),
        .divisor  (rng),
        .done     (div_done),
        .quotient (div_q)
    );

    // stream timing: RAM read plus output register put sample k two cycles after its read;
    // ta/vi wrap to large values before their window, so the top two bits act as range checks
    always_comb begin
        rng      = mx - mn;
        diff     = rd_q - mn;
        nxt      = scnt + 1'b1;
        ta       = nxt - LEAD;
        vi       = nxt - PIPE;
        slope    = 10'sd128 + $signed({2'b00, rd_q}) - $signed({2'b00, bus.wave_out});
        ram_addr = state == STREAM ? scnt[ADDR_W-1:0] : idx;
        ram_we   = (state == CAPTURE && bus.adc_valid) ||
                   (state == NORM && (ph == N_RD ? rng == 8'd0 : ph == N_DIV && div_done));
        ram_wd   = state == CAPTURE ? bus.adc_data : ph == N_RD ? FLAT_LEVEL : div_q;
    end

    // single-port frame RAM with registered read data
    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wd;
        rd_q <= ram[ram_addr];
    end

    // frame sequencer with registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            ph             <= N_RD;
            idx            <= '0;
            mn             <= FULL_SCALE;
            mx             <= '0;
            scnt           <= '0;
            div_start      <= 1'b0;
            div_num        <= '0;
            bus.busy       <= 1'b0;
            bus.tmpl_addr  <= '0;
            bus.wave_valid <= 1'b0;
            bus.wave_out   <= '0;
            bus.dwave_out  <= '0;
            bus.frame_done <= 1'b0;
        end else begin
            div_start      <= 1'b0;
            bus.frame_done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    state    <= CAPTURE;
                    bus.busy <= 1'b1;
                    idx      <= '0;
                    mn       <= FULL_SCALE;
                    mx       <= '0;
                end
                CAPTURE: if (bus.adc_valid) begin
                    idx <= idx + 1'b1;
                    if (bus.adc_data < mn) mn <= bus.adc_data;
                    if (bus.adc_data > mx) mx <= bus.adc_data;
                    if (&idx) begin
                        state <= NORM;
                        ph    <= N_RD;
                    end
                end
                NORM: case (ph)
                    N_RD: if (rng == 8'd0) begin
                        idx <= idx + 1'b1;
                        if (&idx) begin
                            state <= STREAM;
                            scnt  <= '0;
                        end
                    end else begin
                        ph <= N_SUB;
                    end
                    N_SUB: begin
                        div_start <= 1'b1;
                        div_num   <= 16'(diff) * 16'(FULL_SCALE);
                        ph        <= N_DIV;
                    end
                    N_DIV: if (div_done) begin
                        idx <= idx + 1'b1;
                        ph  <= N_RD;
                        if (&idx) begin
                            state <= STREAM;
                            scnt  <= '0;
                        end
                    end
                    default: ph <= N_RD;
                endcase
                STREAM: begin
                    scnt           <= nxt;
                    bus.tmpl_addr  <= ta[ADDR_W+1:ADDR_W] == 2'b00 ? ta[ADDR_W-1:0] : '0;
                    bus.wave_valid <= vi[ADDR_W+1:ADDR_W] == 2'b00;
                    if (vi[ADDR_W+1:ADDR_W] == 2'b00) begin
                        bus.wave_out  <= rd_q;
                        bus.dwave_out <= vi == '0 ? DERIV_ZERO : clamp_u8(slope);
                    end
                    if (vi[ADDR_W+1:ADDR_W] == 2'b01) begin
                        state          <= DONE;
                        bus.busy       <= 1'b0;
                        bus.frame_done <= 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wave_frame_prep.sv
// tb_wave_frame_prep: scoreboard bench driving three instances with template latency 0, 1 and 2
module tb_wave_frame_prep;
    localparam int AW = 8;
    localparam int N  = 1 << AW;
    localparam int ND = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic adc_valid = 1'b0;
    logic [7:0] adc_data = '0;
    logic [ND-1:0] busy;
    logic [ND-1:0] wv;
    logic [ND-1:0] fd;
    logic [ND-1:0] pv = '0;
    logic [7:0] wo [ND];
    logic [7:0] dw [ND];
    logic [AW-1:0] ta [ND];
    logic [AW-1:0] rom [ND];
    logic [15:0] sb [ND][$];
    logic [15:0] exp_e;
    logic [7:0] smp [N];
    logic [7:0] cap_w [N];
    logic [7:0] cap_d [N];
    int run [ND];
    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        wave_frame_prep_if #(.ADDR_W(AW)) bus ();
        logic [AW-1:0] r1;
        logic [AW-1:0] r2;
        assign bus.start     = start;
        assign bus.adc_data  = adc_data;
        assign bus.adc_valid = adc_valid;
        assign busy[g]       = bus.busy;
        assign wv[g]         = bus.wave_valid;
        assign fd[g]         = bus.frame_done;
        assign wo[g]         = bus.wave_out;
        assign dw[g]         = bus.dwave_out;
        assign ta[g]         = bus.tmpl_addr;
        assign rom[g]        = g == 0 ? bus.tmpl_addr : g == 1 ? r1 : r2;
        always @(posedge clk) begin
            r1 <= bus.tmpl_addr;
            r2 <= r1;
        end
        wave_frame_prep #(.ADDR_W(AW), .TMPL_LAT(g)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_frame();
        int mn = 255;
        int mx = 0;
        int n;
        int p = 0;
        int dv;
        for (int i = 0; i < N; i++) begin
            if (int'(smp[i]) < mn) mn = int'(smp[i]);
            if (int'(smp[i]) > mx) mx = int'(smp[i]);
        end
        for (int i = 0; i < N; i++) begin
            n  = mx == mn ? 128 : ((int'(smp[i]) - mn) * 255) / (mx - mn);
            dv = i == 0 ? 128 : 128 + n - p;
            dv = dv < 0 ? 0 : dv > 255 ? 255 : dv;
            for (int d = 0; d < ND; d++) sb[d].push_back({8'(n), 8'(dv)});
            p = n;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 7);
    endtask

    task automatic feed(input int gap, input int poke);
        for (int i = 0; i < N; i++) begin
            adc_data  = smp[i];
            adc_valid = 1'b1;
            start     = (i == poke);
            tick();
            adc_valid = 1'b0;
            adc_data  = 8'd0;
            start     = 1'b0;
            repeat (gap) tick();
        end
    endtask

    task automatic wait_stream();
        for (int c = 0; c < 20000 && wv[0] !== 1'b1; c++) tick();
        chk("stream_seen", 32'(wv[0]), 1);
    endtask

    task automatic wait_done(input bit poke_done);
        for (int c = 0; c < 20000 && fd[0] !== 1'b1; c++) tick();
        chk("frame_done_seen", 32'(fd[0]), 1);
        if (poke_done) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            chk("done_start_ignored", 32'(busy), 0);
            tick();
            chk("still_idle", 32'(busy), 0);
        end
        repeat (2) tick();
        for (int d = 0; d < ND; d++) chk($sformatf("sb_drained%0d", d), 32'(sb[d].size()), 0);
    endtask

    task automatic ramp_fill();
        for (int i = 0; i < N; i++) smp[i] = 8'(50 + i / 2);
    endtask

    task automatic ramp_checks();
        int bad_mono = 0;
        int bad_d = 0;
        for (int i = 1; i < N; i++) if (cap_w[i] < cap_w[i-1]) bad_mono++;
        for (int i = 0; i < N; i++) if (cap_d[i] < 8'd128 || cap_d[i] > 8'd131) bad_d++;
        chk("ramp_first", 32'(cap_w[0]), 0);
        chk("ramp_last", 32'(cap_w[N-1]), 255);
        chk("ramp_monotonic", bad_mono, 0);
        chk("ramp_dwave_range", bad_d, 0);
    endtask

    // monitor: scoreboard pops, template alignment, burst length and frame_done placement
    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (wv[d]) begin
                chk($sformatf("tmpl_align_lat%0d", d), 32'(rom[d]), 32'(run[d]));
                chk($sformatf("sb_avail%0d", d), 32'(sb[d].size() != 0), 1);
                if (sb[d].size() != 0) begin
                    exp_e = sb[d].pop_front();
                    chk($sformatf("sample%0d_lat%0d", run[d], d), 32'({wo[d], dw[d]}), 32'(exp_e));
                end
                if (d == 0 && run[0] < N) begin
                    cap_w[run[0]] = wo[0];
                    cap_d[run[0]] = dw[0];
                end
                run[d]++;
            end
            if (fd[d] || (pv[d] && !wv[d])) chk($sformatf("frame_done_lat%0d", d), 32'(fd[d]), 32'(pv[d] && !wv[d]));
            if (pv[d] && !wv[d]) begin
                chk($sformatf("burst_len_lat%0d", d), run[d], N);
                run[d] = 0;
            end
            pv[d] = wv[d];
            if (!rst_n) begin
                sb[d].delete();
                run[d] = 0;
                pv[d] = 1'b0;
            end
        end
    end

    initial begin
        repeat (3) tick();
        for (int d = 0; d < ND; d++) begin
            chk("rst_busy", 32'(busy[d]), 0);
            chk("rst_valid", 32'(wv[d]), 0);
            chk("rst_done", 32'(fd[d]), 0);
            chk("rst_wave", 32'(wo[d]), 0);
            chk("rst_dwave", 32'(dw[d]), 0);
            chk("rst_tmpl", 32'(ta[d]), 0);
        end
        rst_n = 1'b1;
        tick();

        ramp_fill();
        expect_frame();
        do_start();
        feed(0, -1);
        wait_done(1'b1);
        ramp_checks();

        for (int i = 0; i < N; i++) smp[i] = 8'd77;
        expect_frame();
        do_start();
        feed(0, -1);
        wait_done(1'b0);
        chk("flat_wave", 32'(cap_w[N/2]), 128);
        chk("flat_dwave", 32'(cap_d[N-1]), 128);

        for (int i = 0; i < N; i++) smp[i] = i < N / 2 ? 8'd10 : 8'd200;
        expect_frame();
        do_start();
        feed(0, 40);
        chk("busy_capture_poke", 32'(busy), 7);
        repeat (60) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_norm_poke", 32'(busy), 7);
        wait_stream();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(1'b0);
        chk("sq_up_edge", 32'(cap_d[N/2]), 255);
        chk("sq_up_low", 32'(cap_w[0]), 0);
        chk("sq_up_high", 32'(cap_w[N-1]), 255);

        for (int i = 0; i < N; i++) smp[i] = i < N / 2 ? 8'd200 : 8'd10;
        expect_frame();
        do_start();
        feed(0, -1);
        wait_done(1'b0);
        chk("sq_down_edge", 32'(cap_d[N/2]), 0);

        ramp_fill();
        expect_frame();
        do_start();
        feed(2, -1);
        wait_done(1'b0);
        ramp_checks();

        ramp_fill();
        expect_frame();
        do_start();
        feed(0, -1);
        wait_stream();
        repeat (20) tick();
        rst_n = 1'b0;
        tick();
        chk("abort_valid", 32'(wv), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(fd), 0);
        rst_n = 1'b1;
        repeat (5) tick();
        chk("abort_idle", 32'(busy), 0);

        ramp_fill();
        expect_frame();
        do_start();
        feed(0, -1);
        wait_done(1'b0);
        ramp_checks();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
